// File: rtl/rng_range.sv
// Maps 32-bit random words to uniform integers in [0, RANGE) using Lemire's multiply-and-reject method; optional macro RNG_RANGE_STATS_EN.
// Latency: the sampling edge plus two more (WAIT -> MUL -> CHK push), so out_valid rises after the third edge.
// Backpressure: a new word is fetched only in WAIT with FIFO space; with the FIFO full rng_valid is left pending.
module rng_range #(
    parameter int unsigned RANGE = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rng_valid,
    input  logic [31:0] rng_data,
    output logic        rng_start,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] reject_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [63:0] RANGE64 = 64'(RANGE);
    localparam logic [31:0] T = (RANGE == 0) ? 32'd0 : 32'(64'h1_0000_0000 % RANGE64);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    if (RANGE == 0) begin : g_range_chk
        $error("rng_range: RANGE must be nonzero");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("rng_range: DEPTH must be a power of two in 2..16");
    end

    typedef enum logic [1:0] {WAIT, MUL, CHK} state_t;

    state_t        state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [63:0]   prod_q, prod_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          accept, reject, push, pop;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        prod_d    = prod_q;
        rng_start = 1'b0;
        case (state_q)
            WAIT: begin
                if (!rst && rng_valid && cnt_q < FULL) begin
                    rng_start = 1'b1;
                    word_d    = rng_data;
                    state_d   = MUL;
                end
            end
            MUL: begin
                prod_d  = {32'd0, word_q} * RANGE64;
                state_d = CHK;
            end
            CHK:     state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    // Fraction part below T falls in the biased zone and is thrown away.
    assign accept    = (state_q == CHK) && (prod_q[31:0] >= T);
    assign reject    = (state_q == CHK) && (prod_q[31:0] < T);
    assign push      = accept;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_q[rptr_q] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            word_q  <= '0;
            prod_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            prod_q  <= prod_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= prod_q[63:32];
    end

`ifdef RNG_RANGE_STATS_EN
    logic [15:0] rej_q, rej_d;

    always_comb begin
        rej_d = rej_q;
        if (reject && rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) rej_q <= '0;
        else     rej_q <= rej_d;
    end

    assign reject_cnt = rej_q;
`else
    assign reject_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_rng_range.sv
// Randomized scoreboard bench for rng_range (RANGE=6 main instance, RANGE=1 side instance).
module tb_rng_range;
`ifdef RNG_RANGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam longint unsigned RNG = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        rng_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] rng_data = '0;
    logic        rng_start, out_valid;
    logic [31:0] out_data;
    logic [15:0] reject_cnt;

    logic        rng_valid1 = 1'b1, out_ready1 = 1'b1;
    logic [31:0] rng_data1 = 32'h1234_5678;
    logic        rng_start1, out_valid1;
    logic [31:0] out_data1;
    logic [15:0] reject_cnt1;

    rng_range #(.RANGE(6), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .rng_valid(rng_valid), .rng_data(rng_data),
        .rng_start(rng_start), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .reject_cnt(reject_cnt)
    );

    rng_range #(.RANGE(1), .DEPTH(2)) u_r1 (
        .clk(clk), .rst(rst), .rng_valid(rng_valid1), .rng_data(rng_data1),
        .rng_start(rng_start1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .reject_cnt(reject_cnt1)
    );

    typedef struct {
        logic [31:0] d;
        int unsigned at;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned rej_at[$];
    logic [31:0] src_q[$];
    int unsigned cyc = 0;
    int          exp_rej = 0;
    int          n_cmp = 0, n_bad = 0;
    int          n_start = 0, n_r1 = 0;
    bit          have_word = 0, rand_en = 0, acc_only = 0, prev_start = 0, r1_taken = 0;
    int          ready_pct = 100;
    logic [31:0] cur = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: value = floor(w*RANGE / 2^32); biased when the fractional part is below 2^32 mod RANGE.
    function automatic bit ref_accept(input logic [31:0] w, output logic [31:0] v);
        longint unsigned p, frac, thr;
        p    = longint'(64'(w)) * RNG;
        v    = 32'(p / 64'h1_0000_0000);
        frac = p % 64'h1_0000_0000;
        thr  = 64'h1_0000_0000 % RNG;
        return frac >= thr;
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w, v;
        w = $urandom;
        while (acc_only && !ref_accept(w, v)) w = $urandom;
        return w;
    endfunction

    task automatic step(input bit r);
        logic [31:0] v;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            rej_at.delete();
            exp_rej = 0;
        end
        rst = r;
        if (!have_word) begin
            if (src_q.size() > 0) begin
                cur = src_q.pop_front();
                have_word = 1;
            end else if (rand_en && $urandom_range(0, 3) != 0) begin
                cur = gen_word();
                have_word = 1;
            end
        end
        rng_valid = have_word;
        rng_data  = cur;
        out_ready = ($urandom_range(0, 99) < ready_pct);
        if (r1_taken) rng_data1 = $urandom;
        #1;
        chk("start_legal", 64'(rng_start && (!rng_valid || rst)), 64'd0);
        if (rng_start) begin
            chk("start_back_to_back", 64'(prev_start), 64'd0);
            n_start++;
            if (ref_accept(cur, v)) exp_q.push_back('{d: v, at: cyc + 3});
            else                    rej_at.push_back(cyc + 3);
            have_word = 0;
        end
        prev_start = rng_start;
        r1_taken   = rng_start1;
    endtask

    // Monitor: compares DUT outputs against the scoreboard once per cycle, mid low phase.
    always @(negedge clk) begin
        bit exp_v;
        #3;
        while (rej_at.size() > 0 && rej_at[0] <= cyc) begin
            void'(rej_at.pop_front());
            if (exp_rej < 65535) exp_rej++;
        end
        exp_v = (exp_q.size() > 0) && (exp_q[0].at <= cyc);
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        chk("reject_cnt", 64'(reject_cnt), STATS ? 64'(exp_rej) : 64'd0);
        if (out_valid && out_ready && exp_v) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0].d));
            void'(exp_q.pop_front());
        end
        if (out_valid1) begin
            chk("r1_data", 64'(out_data1), 64'd0);
            n_r1++;
        end
        chk("r1_reject_cnt", 64'(reject_cnt1), 64'd0);
    end

    initial begin
        int base;
        repeat (3) step(1);
        step(0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_reject_cnt", 64'(reject_cnt), 64'd0);
        chk("rst_no_start", 64'(rng_start), 64'd0);

        // Single accepted word: 0xFFFFFFFF -> 5.
        base = n_start;
        src_q.push_back(32'hFFFF_FFFF);
        repeat (8) step(0);
        chk("single_word_starts", 64'(n_start - base), 64'd1);

        // Two rejects then 1; then the MT19937 (seed 5489) first word -> 4.
        src_q.push_back(32'h2AAA_AAAB);
        src_q.push_back(32'h8000_0000);
        src_q.push_back(32'h4000_0000);
        repeat (16) step(0);
        chk("rejects_counted", 64'(reject_cnt), STATS ? 64'd2 : 64'd0);
        src_q.push_back(32'hD091_BB5C);
        repeat (8) step(0);
        chk("mt_first_drained", 64'(exp_q.size()), 64'd0);

        // Back-pressure: FIFO fills to DEPTH then fetch stalls with the word held.
        base = n_start;
        ready_pct = 0; rand_en = 1; acc_only = 1;
        repeat (40) step(0);
        chk("full_starts", 64'(n_start - base), 64'd4);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_rng_valid_held", 64'(rng_valid), 64'd1);
        chk("full_no_start", 64'(rng_start), 64'd0);
        rand_en = 0; ready_pct = 100;
        repeat (20) step(0);
        chk("drain_resume_starts", 64'(n_start - base), 64'd5);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // Random traffic with random back-pressure (covers push+pop on one edge).
        acc_only = 0; rand_en = 1; ready_pct = 50;
        repeat (2000) step(0);
        rand_en = 0; ready_pct = 100;
        repeat (30) step(0);
        chk("random_drained", 64'(exp_q.size()), 64'd0);

        // Reset while a third word sits in MUL with two FIFO entries.
        ready_pct = 0;
        base = n_start;
        src_q.push_back(32'h4000_0000);
        src_q.push_back(32'hFFFF_FFFF);
        src_q.push_back(32'hD091_BB5C);
        for (int i = 0; i < 40 && (n_start - base) < 3; i++) step(0);
        chk("midrst_three_starts", 64'(n_start - base), 64'd3);
        chk("midrst_two_stored", 64'(out_valid), 64'd1);
        step(1);
        step(0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_reject_cnt", 64'(reject_cnt), 64'd0);
        chk("midrst_no_start", 64'(rng_start), 64'd0);
        ready_pct = 100;
        repeat (6) step(0);
        chk("midrst_no_push", 64'(out_valid), 64'd0);

        chk("r1_produced", 64'(n_r1 > 20), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
